frame_capture_writer: RTL

- Captures one camera frame into the 320x240 word-per-pixel on-chip frame memory that the Nios reads for barcode decoding.
- Input is a byte-serial RGB565 stream with vsync/href qualifiers, already synchronous to clk.
- Each pixel is converted to 8-bit luma and written as one 32-bit word at address y*WIDTH+x.
- Drives the memory's second slave port: address, byteenable, chipselect, write, writedata, clken.

---
 rtl/frame_capture_writer.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/frame_capture_writer.sv
// rtl/frame_capture_writer.sv - camera RGB565 byte stream to luma words in frame memory
module frame_capture_writer #(
    parameter int WIDTH      = 320,
    parameter int HEIGHT     = 240,
    parameter int ADDR_W     = 17,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              cam_vsync,
    input  logic              cam_href,
    input  logic              cam_byte_valid,
    input  logic [7:0]        cam_data,
    output logic [ADDR_W-1:0] mem_address,
    output logic [3:0]        mem_byteenable,
    output logic              mem_chipselect,
    output logic              mem_write,
    output logic [31:0]       mem_writedata,
    output logic              mem_clken,
    input  logic              mem_waitrequest,
    output logic              busy,
    output logic              done,
    output logic              short_frame,
    output logic              overflow
);
    localparam int COL_W  = $clog2(WIDTH + 1);
    localparam int LINE_W = $clog2(HEIGHT + 1);
    localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [COL_W-1:0]  WIDTH_C  = COL_W'(WIDTH);
    localparam logic [LINE_W-1:0] HEIGHT_C = LINE_W'(HEIGHT);
    localparam logic [LINE_W-1:0] LAST_C   = LINE_W'(HEIGHT - 1);
    localparam logic [PTR_W:0]    DEPTH_C  = (PTR_W + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_ARMED, S_CAPTURE, S_DRAIN} state_t;
    state_t state, state_nxt;

    logic              vsync_q, href_q, phase;
    logic [7:0]        first_byte;
    logic [COL_W-1:0]  col;
    logic [LINE_W-1:0] line;
    logic [ADDR_W-1:0] line_base;
    logic              s1_valid, s2_valid;
    logic [15:0]       s1_pixel;
    logic [ADDR_W-1:0] s1_addr, s2_addr;
    logic [7:0]        s2_luma, mem_luma;
    logic [ADDR_W-1:0] fifo_addr [FIFO_DEPTH];
    logic [7:0]        fifo_data [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [PTR_W:0]    count;

    logic vsync_fall, vsync_rise, href_rise, href_fall, phase_eff;
    logic pixel_form, line_adv, push_ok, pop;
    logic set_short, drain_done;
    logic [7:0]  r8, g8, b8;
    logic [15:0] luma_sum;

    assign vsync_fall = vsync_q & ~cam_vsync;
    assign vsync_rise = ~vsync_q & cam_vsync;
    assign href_rise  = ~href_q & cam_href;
    assign href_fall  = href_q & ~cam_href;
    assign phase_eff  = href_rise ? 1'b0 : phase;
    assign pixel_form = (state == S_CAPTURE) && cam_href && cam_byte_valid && phase_eff;
    assign line_adv   = (state == S_CAPTURE) && href_fall && (col != '0);
    assign push_ok    = s2_valid && (count != DEPTH_C);
    assign pop        = (count != '0) && (!mem_write || !mem_waitrequest);

    // Bit replication expands 5/6-bit channels to full 8-bit range.
    assign r8 = {s1_pixel[15:11], s1_pixel[15:13]};
    assign g8 = {s1_pixel[10:5],  s1_pixel[10:9]};
    assign b8 = {s1_pixel[4:0],   s1_pixel[4:2]};
    assign luma_sum = 16'd77 * {8'd0, r8} + 16'd150 * {8'd0, g8} + 16'd29 * {8'd0, b8};

    assign mem_byteenable = mem_write ? 4'hF : 4'h0;
    assign mem_chipselect = mem_write;
    assign mem_writedata  = {24'd0, mem_luma};

    always_comb begin
        state_nxt  = state;
        set_short  = 1'b0;
        drain_done = 1'b0;
        case (state)
            S_IDLE:    if (start) state_nxt = S_ARMED;
            S_ARMED:   if (vsync_fall) state_nxt = S_CAPTURE;
            S_CAPTURE: begin
                if (vsync_rise) begin
                    state_nxt = S_DRAIN;
                    set_short = (line < HEIGHT_C);
                end else if (line_adv && line == LAST_C) begin
                    state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (count == '0 && !mem_write && !s1_valid && !s2_valid) begin
                    state_nxt  = S_IDLE;
                    drain_done = 1'b1;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            short_frame <= 1'b0;
            overflow    <= 1'b0;
            mem_clken   <= 1'b0;
        end else begin
            state     <= state_nxt;
            done      <= drain_done;
            mem_clken <= 1'b1;
            if (state == S_IDLE && start) begin
                busy        <= 1'b1;
                short_frame <= 1'b0;
                overflow    <= 1'b0;
            end else begin
                if (drain_done) busy <= 1'b0;
                if (set_short) short_frame <= 1'b1;
                if (s2_valid && count == DEPTH_C) overflow <= 1'b1;
            end
        end
    end

    // Capture datapath: byte pairing, position counters, two pipeline stages.
    always_ff @(posedge clk) begin
        if (reset) begin
            vsync_q <= 1'b0; href_q <= 1'b0; phase <= 1'b0; first_byte <= '0;
            col <= '0; line <= '0; line_base <= '0;
            s1_valid <= 1'b0; s1_pixel <= '0; s1_addr <= '0;
            s2_valid <= 1'b0; s2_luma <= '0; s2_addr <= '0;
        end else begin
            vsync_q <= cam_vsync;
            href_q  <= cam_href;
            if (cam_href && cam_byte_valid) begin
                phase <= ~phase_eff;
                if (!phase_eff) first_byte <= cam_data;
            end else if (href_rise) begin
                phase <= 1'b0;
            end
            if (state == S_ARMED && vsync_fall) begin
                col <= '0; line <= '0; line_base <= '0;
            end else if (pixel_form) begin
                if (col != WIDTH_C) col <= col + COL_W'(1);
            end else if (line_adv) begin
                line      <= line + LINE_W'(1);
                line_base <= line_base + ADDR_W'(WIDTH);
                col       <= '0;
            end
            s1_valid <= pixel_form && (col < WIDTH_C) && (line < HEIGHT_C);
            s1_pixel <= {first_byte, cam_data};
            s1_addr  <= line_base + ADDR_W'(col);
            s2_valid <= s1_valid;
            s2_luma  <= luma_sum[15:8];
            s2_addr  <= s1_addr;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            fifo_addr[wr_ptr] <= s2_addr;
            fifo_data[wr_ptr] <= s2_luma;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0; rd_ptr <= '0; count <= '0;
            mem_write <= 1'b0; mem_address <= '0; mem_luma <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)     rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push_ok, pop})
                2'b10:   count <= count + (PTR_W + 1)'(1);
                2'b01:   count <= count - (PTR_W + 1)'(1);
                default: count <= count;
            endcase
            // Outputs only move when no write is outstanding or the current one completes.
            if (!mem_write || !mem_waitrequest) begin
                mem_write <= pop;
                if (pop) begin
                    mem_address <= fifo_addr[rd_ptr];
                    mem_luma    <= fifo_data[rd_ptr];
                end
            end
        end
    end
endmodule
